// File: rtl/model_arb_if.sv
// Bundle of the two requester channels, the model datapath tap and the response
// channel shared by model_arb and whatever drives it.
interface model_arb_if #(
   parameter int WIDTH = 8
);
   logic             a_valid;
   logic [WIDTH-1:0] a_data;
   logic             a_ready;
   logic             b_valid;
   logic [WIDTH-1:0] b_data;
   logic             b_ready;
   logic [WIDTH-1:0] model_in;
   logic [WIDTH-1:0] model_out;
   logic             rsp_valid;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_ready;
   logic             busy;

   modport slave (
      input  a_valid, a_data, b_valid, b_data, model_out, rsp_ready,
      output a_ready, b_ready, model_in, rsp_valid, rsp_id, rsp_data, busy
   );

   modport master (
      output a_valid, a_data, b_valid, b_data, model_out, rsp_ready,
      input  a_ready, b_ready, model_in, rsp_valid, rsp_id, rsp_data, busy
   );
endinterface

// File: rtl/model_arb.sv
// Round-robin front end that time-shares one model datapath between requesters
// A and B, one outstanding sample at a time, with a tagged response channel.
module model_arb #(
   parameter int WIDTH = 8,
   parameter int LAT   = 1
) (
   input logic        clk,
   input logic        rst_n,
   model_arb_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_last;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_modelIn;
   logic             r_rspValid;
   logic             r_rspId;
   logic [WIDTH-1:0] r_rspData;

   logic             w_idle;
   logic             w_grantA;
   logic             w_grantB;
   logic             w_accept;
   logic [WIDTH-1:0] w_acceptData;

   // B wins when it is alone, or when both ask and A was served last.
   assign w_idle       = (r_state == IDLE);
   assign w_grantB     = bus.b_valid && (!bus.a_valid || !r_last);
   assign w_grantA     = bus.a_valid && !w_grantB;
   assign w_accept     = w_idle && (bus.a_valid || bus.b_valid);
   assign w_acceptData = w_grantB ? bus.b_data : bus.a_data;

   // Readies are gated by rst_n so they read 0 while reset is held.
   assign bus.a_ready   = rst_n && w_idle && w_grantA;
   assign bus.b_ready   = rst_n && w_idle && w_grantB;
   assign bus.busy      = (r_state != IDLE);
   assign bus.model_in  = r_modelIn;
   assign bus.rsp_valid = r_rspValid;
   assign bus.rsp_id    = r_rspId;
   assign bus.rsp_data  = r_rspData;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_last     <= 1'b1;
         r_cnt      <= 4'd0;
         r_modelIn  <= '0;
         r_rspValid <= 1'b0;
         r_rspId    <= 1'b0;
         r_rspData  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_modelIn <= w_acceptData;
                  r_rspId   <= w_grantB;
                  r_last    <= w_grantB;
                  r_cnt     <= 4'(LAT);
                  r_state   <= WAIT;
               end
            end
            WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_rspData  <= bus.model_out;
                  r_rspValid <= 1'b1;
                  r_state    <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  r_rspValid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_model_arb.sv
// Directed bench for model_arb: a cycle model of the arbiter feeds a scoreboard
// of expected responses; two extra instances cover the LAT=0 and LAT=7 builds.
module tb_model_arb;

   localparam int WIDTH    = 8;
   localparam int MAIN_LAT = 1;

   typedef struct packed {
      logic       id;
      logic [7:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   model_arb_if #(.WIDTH(WIDTH)) mainIf ();
   model_arb_if #(.WIDTH(WIDTH)) sw0If ();
   model_arb_if #(.WIDTH(WIDTH)) sw7If ();

   assign mainIf.model_out = ~mainIf.model_in;
   assign sw0If.model_out  = sw0If.model_in ^ 8'hA5;
   assign sw7If.model_out  = sw7If.model_in ^ 8'hA5;

   model_arb #(.WIDTH(WIDTH), .LAT(MAIN_LAT)) dutMain (.clk(clk), .rst_n(rst_n), .bus(mainIf));
   model_arb #(.WIDTH(WIDTH), .LAT(0))        dutLat0 (.clk(clk), .rst_n(rst_n), .bus(sw0If));
   model_arb #(.WIDTH(WIDTH), .LAT(7))        dutLat7 (.clk(clk), .rst_n(rst_n), .bus(sw7If));

   exp_t       expQ[$];
   int         tests       = 0;
   int         failed      = 0;
   int         cycle       = 0;
   int         mAccept     = 0;
   int         acceptCount = 0;
   logic       mBusy       = 1'b0;
   logic       mLast       = 1'b1;
   logic [7:0] mInData     = 8'h00;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic aV, input logic [7:0] aD, input logic bV,
                                input logic [7:0] bD, input logic rr);
      mainIf.a_valid   = aV;
      mainIf.a_data    = aD;
      mainIf.b_valid   = bV;
      mainIf.b_data    = bD;
      mainIf.rsp_ready = rr;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_a_ready"},   32'(mainIf.a_ready),   32'd0);
      checkOutput({tag, "_b_ready"},   32'(mainIf.b_ready),   32'd0);
      checkOutput({tag, "_busy"},      32'(mainIf.busy),      32'd0);
      checkOutput({tag, "_rsp_valid"}, 32'(mainIf.rsp_valid), 32'd0);
      checkOutput({tag, "_rsp_id"},    32'(mainIf.rsp_id),    32'd0);
      checkOutput({tag, "_rsp_data"},  32'(mainIf.rsp_data),  32'd0);
      checkOutput({tag, "_model_in"},  32'(mainIf.model_in),  32'd0);
   endtask

   // One clock of the reference model: checks at the falling edge, then returns
   // just after the next rising edge so the caller can drive new inputs.
   task automatic tick();
      logic busyNow;
      logic expA;
      logic expB;
      logic expValid;
      exp_t e;
      @(negedge clk);
      if (!rst_n) begin
         checkOutput("rst_a_ready", 32'(mainIf.a_ready), 32'd0);
         checkOutput("rst_b_ready", 32'(mainIf.b_ready), 32'd0);
         checkOutput("rst_busy",    32'(mainIf.busy),    32'd0);
      end else begin
         busyNow = mBusy;
         expA    = 1'b0;
         expB    = 1'b0;
         if (!busyNow) begin
            if (mainIf.a_valid && mainIf.b_valid) begin
               if (mLast) expA = 1'b1;
               else       expB = 1'b1;
            end else begin
               expA = mainIf.a_valid;
               expB = mainIf.b_valid;
            end
         end
         checkOutput("a_ready", 32'(mainIf.a_ready), 32'(expA));
         checkOutput("b_ready", 32'(mainIf.b_ready), 32'(expB));
         checkOutput("busy", 32'(mainIf.busy), 32'(busyNow && (cycle > mAccept)));
         expValid = busyNow && (cycle >= mAccept + 2 + MAIN_LAT);
         checkOutput("rsp_valid", 32'(mainIf.rsp_valid), 32'(expValid));
         if (busyNow && (cycle == mAccept + 1))
            checkOutput("model_in", 32'(mainIf.model_in), 32'(mInData));
         if (expValid && (expQ.size() > 0)) begin
            checkOutput("rsp_id",   32'(mainIf.rsp_id),   32'(expQ[0].id));
            checkOutput("rsp_data", 32'(mainIf.rsp_data), 32'(expQ[0].data));
            if (mainIf.rsp_ready) begin
               void'(expQ.pop_front());
               mBusy = 1'b0;
            end
         end
         if (expA || expB) begin
            mInData = expA ? mainIf.a_data : mainIf.b_data;
            e.id    = expB;
            e.data  = ~mInData;
            expQ.push_back(e);
            mLast   = expB;
            mBusy   = 1'b1;
            mAccept = cycle;
            acceptCount++;
         end
      end
      @(posedge clk);
      cycle++;
      #1;
   endtask

   task automatic runUntilAccepts(input int n, input string tag);
      int target;
      int k;
      target = acceptCount + n;
      k      = 0;
      while ((acceptCount < target) && (k < 60)) begin
         tick();
         k++;
      end
      checkOutput({tag, "_accepts"}, 32'(acceptCount), 32'(target));
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while ((expQ.size() > 0) && (k < 60)) begin
         tick();
         k++;
      end
      checkOutput({tag, "_drain"}, 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] stream [8];
      int         lat0;
      int         lat7;
      logic [7:0] d0;
      logic [7:0] d7;

      stream = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h80, 8'h01, 8'h7E, 8'hC3};
      sw0If.a_valid = 1'b0; sw0If.a_data = 8'h00; sw0If.b_valid = 1'b0;
      sw0If.b_data  = 8'h00; sw0If.rsp_ready = 1'b1;
      sw7If.a_valid = 1'b0; sw7If.a_data = 8'h00; sw7If.b_valid = 1'b0;
      sw7If.b_data  = 8'h00; sw7If.rsp_ready = 1'b1;

      // Reset with A already requesting; it must be taken in the first live cycle.
      rst_n = 1'b0;
      applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
      #1;
      checkResetValues("por");
      tick();
      tick();
      rst_n = 1'b1;
      runUntilAccepts(1, "singleA");
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      drain("singleA");

      applyStimulus(1'b1, 8'h01, 1'b1, 8'h02, 1'b1);
      runUntilAccepts(4, "contend");
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      drain("contend");

      // Response stalled five cycles while B waits; B goes the cycle after release.
      applyStimulus(1'b1, 8'h55, 1'b1, 8'hAA, 1'b0);
      runUntilAccepts(1, "bpA");
      applyStimulus(1'b0, 8'h00, 1'b1, 8'hAA, 1'b0);
      for (int i = 0; i < 7; i++) tick();
      applyStimulus(1'b0, 8'h00, 1'b1, 8'hAA, 1'b1);
      tick();
      tick();
      checkOutput("bp_b_accepted", 32'(acceptCount), 32'd7);
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      drain("bpB");

      applyStimulus(1'b0, 8'h00, 1'b1, 8'h77, 1'b1);
      runUntilAccepts(1, "abort");
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetValues("midwait");
      expQ.delete();
      mBusy = 1'b0;
      mLast = 1'b1;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
      runUntilAccepts(1, "afterRst");
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      drain("afterRst");

      for (int i = 0; i < 8; i++) begin
         if ((i % 2) == 0) applyStimulus(1'b1, stream[i], 1'b0, 8'h00, 1'b1);
         else              applyStimulus(1'b0, 8'h00, 1'b1, stream[i], 1'b1);
         runUntilAccepts(1, "stream");
         applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      end
      drain("stream");

      // Latency sweep on the LAT=0 and LAT=7 builds, measured from the handshake cycle.
      lat0 = -1; lat7 = -1; d0 = 8'h00; d7 = 8'h00;
      sw0If.a_valid = 1'b1; sw0If.a_data = 8'hFF;
      sw7If.a_valid = 1'b1; sw7If.a_data = 8'hFF;
      @(negedge clk);
      checkOutput("sw0_a_ready", 32'(sw0If.a_ready), 32'd1);
      checkOutput("sw7_a_ready", 32'(sw7If.a_ready), 32'd1);
      @(posedge clk);
      #1;
      sw0If.a_valid = 1'b0;
      sw7If.a_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (sw0If.rsp_valid && (lat0 < 0)) begin
            lat0 = k;
            d0   = sw0If.rsp_data;
         end
         if (sw7If.rsp_valid && (lat7 < 0)) begin
            lat7 = k;
            d7   = sw7If.rsp_data;
         end
         @(posedge clk);
         #1;
      end
      checkOutput("sw0_latency", 32'(lat0), 32'd2);
      checkOutput("sw7_latency", 32'(lat7), 32'd9);
      checkOutput("sw0_data",    32'(d0),   32'h5A);
      checkOutput("sw7_data",    32'(d7),   32'h5A);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
